// File: rtl/fp16_pkg.sv
// Shared binary16 definitions: field layout, bias, rounding modes and flag indices
// for the fp16 datapath library.
package fp16_pkg;

    localparam int unsigned FP16_W      = 16;
    localparam int unsigned FP16_EXP_W  = 5;
    localparam int unsigned FP16_MANT_W = 10;
    localparam int unsigned FP16_SIG_W  = FP16_MANT_W + 1;
    localparam int unsigned FP16_BIAS   = 15;

    localparam logic [FP16_EXP_W-1:0] FP16_EXP_ONES = '1;

    typedef struct packed {
        logic                   sign;
        logic [FP16_EXP_W-1:0]  exp;
        logic [FP16_MANT_W-1:0] mant;
    } fp16_t;

    typedef enum logic [1:0] {
        RM_RTZ = 2'd0,
        RM_RNE = 2'd1,
        RM_RUP = 2'd2,
        RM_RDN = 2'd3
    } rm_e;

    localparam int unsigned FLAG_W        = 3;
    localparam int unsigned FLAG_INEXACT  = 0;
    localparam int unsigned FLAG_OVERFLOW = 1;
    localparam int unsigned FLAG_INVALID  = 2;

endpackage

// File: rtl/fp_round_inc.sv
// Combinational round-increment decision shared by the fp-to-int and fp-narrowing blocks.
module fp_round_inc
    import fp16_pkg::*;
(
    input  rm_e  i_rm,
    input  logic i_sign,
    input  logic i_lsb,
    input  logic i_guard,
    input  logic i_sticky,
    output logic o_inc_c
);

    always_comb begin
        o_inc_c = 1'b0;
        case (i_rm)
            RM_RTZ: o_inc_c = 1'b0;
            RM_RNE: o_inc_c = i_guard && (i_sticky || i_lsb);
            RM_RUP: o_inc_c = !i_sign && (i_guard || i_sticky);
            RM_RDN: o_inc_c = i_sign && (i_guard || i_sticky);
        endcase
    end

endmodule

// File: rtl/fp16_to_int_pipe.sv
// Three-stage binary16 -> signed integer converter with rounding modes, flags and
// valid/ready backpressure. Define FP16_TO_INT_STICKY_FLAGS_EN for sticky flag accumulation.
module fp16_to_int_pipe
    import fp16_pkg::*;
#(
    parameter int unsigned OUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FP16_W-1:0]    in_fp,
    input  logic [1:0]           in_rm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_int,
    output logic                 out_invalid,
    output logic                 out_overflow,
    output logic                 out_inexact
`ifdef FP16_TO_INT_STICKY_FLAGS_EN
    ,
    input  logic                 flags_clr,
    output logic [FLAG_W-1:0]    sticky_flags
`endif
);

    localparam int unsigned MAG_W        = ((OUT_W > 17) ? OUT_W : 17) + 1;
    localparam int unsigned RSH_BASE     = FP16_BIAS + FP16_MANT_W;
    localparam int unsigned ALIGN_FRAC_W = 25;
    localparam int unsigned EXT_W        = FP16_SIG_W + ALIGN_FRAC_W;
    localparam int unsigned RSH_W        = 5;
    localparam int unsigned LSH_W        = 3;

    localparam logic [OUT_W-1:0] INT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] INT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [MAG_W-1:0] POS_LIM = MAG_W'(INT_MAX);
    localparam logic [MAG_W-1:0] NEG_LIM = MAG_W'(INT_MIN);

    // Stage load enables: a stage loads when empty or when its successor moves.
    logic w_s1_ld, w_s2_ld, w_s3_ld;
    logic r_v1, r_v2;

    assign w_s3_ld  = !out_valid || out_ready;
    assign w_s2_ld  = !r_v2 || w_s3_ld;
    assign w_s1_ld  = !r_v1 || w_s2_ld;
    assign in_ready = w_s1_ld;

    // S1: unpack and classify, precompute alignment shifts.
    fp16_t            w_fp;
    logic [RSH_W-1:0] w_rsh;
    logic [LSH_W-1:0] w_lsh;

    assign w_fp  = fp16_t'(in_fp);
    assign w_rsh = (w_fp.exp == '0)                      ? RSH_W'(RSH_BASE - 1) :
                   (w_fp.exp <= FP16_EXP_W'(RSH_BASE))   ? RSH_W'(FP16_EXP_W'(RSH_BASE) - w_fp.exp) :
                                                           '0;
    assign w_lsh = (w_fp.exp > FP16_EXP_W'(RSH_BASE))    ? LSH_W'(w_fp.exp - FP16_EXP_W'(RSH_BASE)) :
                                                           '0;

    logic                  r1_sign, r1_nan, r1_inf;
    logic [FP16_SIG_W-1:0] r1_sig;
    logic [RSH_W-1:0]      r1_rsh;
    logic [LSH_W-1:0]      r1_lsh;
    rm_e                   r1_rm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r1_sign <= 1'b0;
            r1_nan  <= 1'b0;
            r1_inf  <= 1'b0;
            r1_sig  <= '0;
            r1_rsh  <= '0;
            r1_lsh  <= '0;
            r1_rm   <= RM_RTZ;
        end else if (w_s1_ld) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r1_sign <= w_fp.sign;
                r1_nan  <= (w_fp.exp == FP16_EXP_ONES) && (w_fp.mant != '0);
                r1_inf  <= (w_fp.exp == FP16_EXP_ONES) && (w_fp.mant == '0);
                r1_sig  <= {(w_fp.exp != '0), w_fp.mant};
                r1_rsh  <= w_rsh;
                r1_lsh  <= w_lsh;
                r1_rm   <= rm_e'(in_rm);
            end
        end
    end

    // S2: align to integer + guard + sticky, then apply the rounding increment.
    logic [EXT_W-1:0] w_ext;
    logic [MAG_W-1:0] w_int, w_mag_rnd;
    logic             w_guard, w_sticky, w_inc_c;

    assign w_ext    = {r1_sig, ALIGN_FRAC_W'(0)} >> r1_rsh;
    assign w_int    = MAG_W'(w_ext[EXT_W-1 -: FP16_SIG_W]) << r1_lsh;
    assign w_guard  = w_ext[ALIGN_FRAC_W-1];
    assign w_sticky = |w_ext[ALIGN_FRAC_W-2:0];

    fp_round_inc u_round_inc (
        .i_rm     (r1_rm),
        .i_sign   (r1_sign),
        .i_lsb    (w_int[0]),
        .i_guard  (w_guard),
        .i_sticky (w_sticky),
        .o_inc_c  (w_inc_c)
    );

    assign w_mag_rnd = w_int + MAG_W'(w_inc_c);

    logic             r2_sign, r2_nan, r2_inf, r2_inexact;
    logic [MAG_W-1:0] r2_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2       <= 1'b0;
            r2_sign    <= 1'b0;
            r2_nan     <= 1'b0;
            r2_inf     <= 1'b0;
            r2_inexact <= 1'b0;
            r2_mag     <= '0;
        end else if (w_s2_ld) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r2_sign    <= r1_sign;
                r2_nan     <= r1_nan;
                r2_inf     <= r1_inf;
                r2_inexact <= w_guard || w_sticky;
                r2_mag     <= w_mag_rnd;
            end
        end
    end

    // S3: negate, saturate against the signed limits, and resolve flags.
    logic [MAG_W-1:0]  w_mag_signed;
    logic              w_sat;
    logic [OUT_W-1:0]  w_s3_int;
    logic [FLAG_W-1:0] w_s3_flags;

    assign w_mag_signed = r2_sign ? (~r2_mag + MAG_W'(1)) : r2_mag;
    assign w_sat        = r2_sign ? (r2_mag > NEG_LIM) : (r2_mag > POS_LIM);

    always_comb begin
        w_s3_int                 = OUT_W'(w_mag_signed);
        w_s3_flags               = '0;
        w_s3_flags[FLAG_INEXACT] = r2_inexact;
        if (r2_nan) begin
            w_s3_int                 = '0;
            w_s3_flags               = '0;
            w_s3_flags[FLAG_INVALID] = 1'b1;
        end else if (r2_inf || w_sat) begin
            w_s3_int                  = r2_sign ? INT_MIN : INT_MAX;
            w_s3_flags                = '0;
            w_s3_flags[FLAG_OVERFLOW] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_int      <= '0;
            out_invalid  <= 1'b0;
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
        end else if (w_s3_ld) begin
            out_valid <= r_v2;
            if (r_v2) begin
                out_int      <= w_s3_int;
                out_invalid  <= w_s3_flags[FLAG_INVALID];
                out_overflow <= w_s3_flags[FLAG_OVERFLOW];
                out_inexact  <= w_s3_flags[FLAG_INEXACT];
            end
        end
    end

`ifdef FP16_TO_INT_STICKY_FLAGS_EN
    // A transferring beat's flags take priority over a coincident clear.
    logic [FLAG_W-1:0] r_sticky;
    logic [FLAG_W-1:0] w_out_flags;

    always_comb begin
        w_out_flags                = '0;
        w_out_flags[FLAG_INVALID]  = out_invalid;
        w_out_flags[FLAG_OVERFLOW] = out_overflow;
        w_out_flags[FLAG_INEXACT]  = out_inexact;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sticky <= '0;
        end else if (out_valid && out_ready) begin
            r_sticky <= (flags_clr ? '0 : r_sticky) | w_out_flags;
        end else if (flags_clr) begin
            r_sticky <= '0;
        end
    end

    assign sticky_flags = r_sticky;
`endif

endmodule

// File: tb/tb_fp16_to_int_pipe.sv
// Self-checking bench for fp16_to_int_pipe at OUT_W=16 and OUT_W=32 with a queue scoreboard.
module tb_fp16_to_int_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_fp;
    logic [1:0]  in_rm;

    logic        in_ready16, out_valid16, inv16, ovf16, inx16;
    logic [15:0] out_int16;
    logic        in_ready32, out_valid32, inv32, ovf32, inx32;
    logic [31:0] out_int32;
`ifdef FP16_TO_INT_STICKY_FLAGS_EN
    logic        flags_clr;
    logic [2:0]  sticky16, sticky32;
`endif

    always #5 clk = ~clk;

    fp16_to_int_pipe #(.OUT_W(16)) u_dut16 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready16),
        .in_fp        (in_fp),
        .in_rm        (in_rm),
        .out_valid    (out_valid16),
        .out_ready    (out_ready),
        .out_int      (out_int16),
        .out_invalid  (inv16),
        .out_overflow (ovf16),
        .out_inexact  (inx16)
`ifdef FP16_TO_INT_STICKY_FLAGS_EN
        ,
        .flags_clr    (flags_clr),
        .sticky_flags (sticky16)
`endif
    );

    fp16_to_int_pipe #(.OUT_W(32)) u_dut32 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready32),
        .in_fp        (in_fp),
        .in_rm        (in_rm),
        .out_valid    (out_valid32),
        .out_ready    (out_ready),
        .out_int      (out_int32),
        .out_invalid  (inv32),
        .out_overflow (ovf32),
        .out_inexact  (inx32)
`ifdef FP16_TO_INT_STICKY_FLAGS_EN
        ,
        .flags_clr    (flags_clr),
        .sticky_flags (sticky32)
`endif
    );

    typedef struct packed {
        logic [15:0] fp;
        logic [1:0]  rm;
        logic [2:0]  flags;
        logic [31:0] val;
    } exp_t;

    exp_t q16[$];
    exp_t q32[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference: exact value scaled by 2^24, rounded on the fraction, then range-checked.
    function automatic exp_t ref_conv(input logic [15:0] fp, input logic [1:0] rm, input int w);
        exp_t        r;
        logic        sign;
        logic [4:0]  ex;
        logic [9:0]  man;
        longint      maxp, minn, sig, scaled, ip, fr, sv, half;
        sign = fp[15];
        ex   = fp[14:10];
        man  = fp[9:0];
        r.fp = fp;
        r.rm = rm;
        maxp = (longint'(1) <<< (w - 1)) - 1;
        minn = -(longint'(1) <<< (w - 1));
        half = longint'(1) <<< 23;
        if (ex == 5'h1F && man != 10'd0) begin
            r.flags = 3'b100;
            r.val   = 32'd0;
            return r;
        end
        if (ex == 5'h1F) begin
            r.flags = 3'b010;
            r.val   = sign ? 32'(minn) : 32'(maxp);
            return r;
        end
        sig    = (ex == 5'd0) ? longint'(man) : 1024 + longint'(man);
        scaled = sig <<< ((ex == 5'd0) ? 0 : int'(ex) - 1);
        ip     = scaled >>> 24;
        fr     = scaled & ((longint'(1) <<< 24) - 1);
        case (rm)
            2'd1: if (fr > half || (fr == half && ip[0])) ip = ip + 1;
            2'd2: if (!sign && fr != 0) ip = ip + 1;
            2'd3: if (sign && fr != 0) ip = ip + 1;
            default: ;
        endcase
        sv = sign ? -ip : ip;
        if (sv > maxp) begin
            r.flags = 3'b010;
            r.val   = 32'(maxp);
        end else if (sv < minn) begin
            r.flags = 3'b010;
            r.val   = 32'(minn);
        end else begin
            r.flags = {2'b00, (fr != 0)};
            r.val   = 32'(sv);
        end
        return r;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (out_valid16 !== 1'b0 || out_valid32 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid got %b/%b exp 0/0", out_valid16, out_valid32);
        end
        n_checks++;
        if (out_int16 !== 16'd0 || out_int32 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_out_int got %h/%h exp 0/0", out_int16, out_int32);
        end
        n_checks++;
        if ({inv16, ovf16, inx16, inv32, ovf32, inx32} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 000000", {inv16, ovf16, inx16, inv32, ovf32, inx32});
        end
        n_checks++;
        if (in_ready16 !== 1'b1 || in_ready32 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b/%b exp 1/1", in_ready16, in_ready32);
        end
`ifdef FP16_TO_INT_STICKY_FLAGS_EN
        n_checks++;
        if (sticky16 !== 3'b000 || sticky32 !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_sticky got %b/%b exp 000/000", sticky16, sticky32);
        end
`endif
    endtask

    // Back-to-back stream of directed corner cases plus random operands.
    task automatic test_convert();
        logic [15:0] fps[$];
        logic [1:0]  rms[$];
        int          n;
        fps = '{16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00, 16'h4100, 16'hB800, 16'hB800,
                16'hF800, 16'h7BFF, 16'h7C00, 16'hFC00, 16'h7E00, 16'h0001, 16'h0001,
                16'h8000, 16'h8001, 16'h3C00, 16'h3800, 16'h3A00, 16'hBE00, 16'h7800};
        rms = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3, 2'd0,
                2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1,
                2'd3, 2'd3, 2'd1, 2'd1, 2'd1, 2'd3, 2'd2};
        for (int i = 0; i < 40; i++) begin
            fps.push_back(16'($urandom()));
            rms.push_back(2'($urandom_range(3, 0)));
        end
        n = fps.size();
        @(posedge clk); #1;
        fork
            begin
                int b;
                for (int i = 0; i < n; i++) begin
                    in_valid = 1'b1;
                    in_fp    = fps[i];
                    in_rm    = rms[i];
                    b = 0;
                    @(negedge clk);
                    while (!in_ready16 && b < 100) begin
                        @(negedge clk);
                        b++;
                    end
                    if (!in_ready16) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL convert_drive_timeout beat %0d in_ready stuck 0 exp 1", i);
                    end
                    q16.push_back(ref_conv(fps[i], rms[i], 16));
                    q32.push_back(ref_conv(fps[i], rms[i], 32));
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                int   got, cyc;
                exp_t e16, e32;
                got = 0;
                cyc = 0;
                while (got < n && cyc < 2000) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid16 && out_ready) begin
                        n_checks++;
                        if (q16.size() == 0 || q32.size() == 0) begin
                            n_fail++;
                            $display("FAIL convert_unexpected_output got int=%h exp no beat", out_int16);
                        end else begin
                            e16 = q16.pop_front();
                            e32 = q32.pop_front();
                            if (out_int16 !== e16.val[15:0] || {inv16, ovf16, inx16} !== e16.flags) begin
                                n_fail++;
                                $display("FAIL convert16 fp=%h rm=%0d got int=%h flags=%b exp int=%h flags=%b",
                                         e16.fp, e16.rm, out_int16, {inv16, ovf16, inx16}, e16.val[15:0], e16.flags);
                            end
                            n_checks++;
                            if (out_valid32 !== 1'b1 || out_int32 !== e32.val || {inv32, ovf32, inx32} !== e32.flags) begin
                                n_fail++;
                                $display("FAIL convert32 fp=%h rm=%0d got v=%b int=%h flags=%b exp int=%h flags=%b",
                                         e32.fp, e32.rm, out_valid32, out_int32, {inv32, ovf32, inx32}, e32.val, e32.flags);
                            end
                        end
                        got++;
                    end
                end
                n_checks++;
                if (got != n) begin
                    n_fail++;
                    $display("FAIL convert_count got %0d beats exp %0d", got, n);
                end
            end
        join
    endtask

    // Ten-beat burst with a five-cycle output stall in the middle.
    task automatic test_backpressure();
        logic [15:0] fps[$];
        logic [1:0]  rms[$];
        int          n;
        fps = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
                16'hC600, 16'h3E00, 16'h4100, 16'hB800, 16'h7BFF};
        rms = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd1, 2'd3, 2'd0};
        n = fps.size();
        @(posedge clk); #1;
        fork
            begin
                int b;
                for (int i = 0; i < n; i++) begin
                    in_valid = 1'b1;
                    in_fp    = fps[i];
                    in_rm    = rms[i];
                    b = 0;
                    @(negedge clk);
                    while (!in_ready16 && b < 100) begin
                        @(negedge clk);
                        b++;
                    end
                    if (!in_ready16) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL bp_drive_timeout beat %0d in_ready stuck 0 exp 1", i);
                    end
                    q16.push_back(ref_conv(fps[i], rms[i], 16));
                    q32.push_back(ref_conv(fps[i], rms[i], 32));
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
            end
            begin
                int   got, cyc;
                exp_t e16, e32;
                got = 0;
                cyc = 0;
                while (got < n && cyc < 500) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid16 && out_ready) begin
                        n_checks++;
                        if (q16.size() == 0 || q32.size() == 0) begin
                            n_fail++;
                            $display("FAIL bp_unexpected_output got int=%h exp no beat", out_int16);
                        end else begin
                            e16 = q16.pop_front();
                            e32 = q32.pop_front();
                            if (out_int16 !== e16.val[15:0] || {inv16, ovf16, inx16} !== e16.flags) begin
                                n_fail++;
                                $display("FAIL bp16 fp=%h got int=%h flags=%b exp int=%h flags=%b",
                                         e16.fp, out_int16, {inv16, ovf16, inx16}, e16.val[15:0], e16.flags);
                            end
                            n_checks++;
                            if (out_int32 !== e32.val || {inv32, ovf32, inx32} !== e32.flags) begin
                                n_fail++;
                                $display("FAIL bp32 fp=%h got int=%h flags=%b exp int=%h flags=%b",
                                         e32.fp, out_int32, {inv32, ovf32, inx32}, e32.val, e32.flags);
                            end
                        end
                        got++;
                    end
                end
                n_checks++;
                if (got != n) begin
                    n_fail++;
                    $display("FAIL bp_count got %0d beats exp %0d", got, n);
                end
            end
            begin
                logic [15:0] held;
                logic [2:0]  hf;
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = out_int16;
                hf   = {inv16, ovf16, inx16};
                n_checks++;
                if (out_valid16 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_stall_valid got %b exp 1", out_valid16);
                end
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    n_checks++;
                    if (out_valid16 !== 1'b1 || out_int16 !== held || {inv16, ovf16, inx16} !== hf) begin
                        n_fail++;
                        $display("FAIL bp_stall_hold cycle %0d got v=%b int=%h flags=%b exp v=1 int=%h flags=%b",
                                 k, out_valid16, out_int16, {inv16, ovf16, inx16}, held, hf);
                    end
                end
                n_checks++;
                if (in_ready16 !== 1'b0 || in_ready32 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_in_ready_full got %b/%b exp 0/0", in_ready16, in_ready32);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        n_checks++;
        if (q16.size() != 0 || q32.size() != 0) begin
            n_fail++;
            $display("FAIL bp_leftover got %0d/%0d queued exp 0/0", q16.size(), q32.size());
        end
    endtask

    task automatic test_reset_midburst();
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_fp    = 16'h4200;
        in_rm    = 2'd0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid16 !== 1'b0 || out_valid32 !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_out_valid got %b/%b exp 0/0", out_valid16, out_valid32);
        end
        n_checks++;
        if (in_ready16 !== 1'b1 || out_int16 !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_state got in_ready=%b int=%h exp in_ready=1 int=0000", in_ready16, out_int16);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (out_valid16 !== 1'b0 || out_valid32 !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_flushed got %b/%b exp 0/0", out_valid16, out_valid32);
        end
    endtask

`ifdef FP16_TO_INT_STICKY_FLAGS_EN
    task automatic test_sticky();
        int b;
        @(posedge clk); #1;
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sticky16 !== 3'b000) begin
            n_fail++;
            $display("FAIL sticky_clear got %b exp 000", sticky16);
        end
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_fp    = 16'h7E00;
        in_rm    = 2'd0;
        @(posedge clk); #1;
        in_fp    = 16'h4100;
        in_rm    = 2'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (sticky16 !== 3'b101 || sticky32 !== 3'b101) begin
            n_fail++;
            $display("FAIL sticky_accum got %b/%b exp 101/101", sticky16, sticky32);
        end
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_fp    = 16'h3E00;
        in_rm    = 2'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        b = 0;
        @(negedge clk);
        while (!out_valid16 && b < 20) begin
            @(negedge clk);
            b++;
        end
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sticky16 !== 3'b001 || sticky32 !== 3'b001) begin
            n_fail++;
            $display("FAIL sticky_clr_xfer got %b/%b exp 001/001", sticky16, sticky32);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_fp     = 16'd0;
        in_rm     = 2'd0;
        out_ready = 1'b1;
`ifdef FP16_TO_INT_STICKY_FLAGS_EN
        flags_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_convert();
        test_backpressure();
        test_reset_midburst();
`ifdef FP16_TO_INT_STICKY_FLAGS_EN
        test_sticky();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
